alu_issue_seq: RTL and testbench
================================

# alu_issue_seq

Command sequencer that sits directly upstream of the 4-bit combinational ALU. It accepts operation commands over a valid/ready handshake and drives registered operands and control into the ALU. After one settle cycle it captures the ALU result and flags, and returns them over a second valid/ready handshake. It keeps an accumulator so commands can chain on the previous result, and keeps saturating activity counters.

## Interface
- `W`, default 4: operand/result width; must equal the ALU width.
- `CNT_W`, default 8: width of the statistics counters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_op` in 3: ALU control code.
- `cmd_a` in W: operand A.
- `cmd_b` in W: operand B.
- `cmd_use_acc` in 1: when 1, operand A is taken from the accumulator and `cmd_a` is ignored.
- `acc_clr` in 1: synchronous accumulator clear.
- `alu_a` out W: registered operand A to the ALU.
- `alu_b` out W: registered operand B to the ALU.
- `alu_ctrl` out 3: registered control to the ALU.
- `alu_res` in W: ALU result.
- `alu_car` in 1: ALU carry.
- `alu_of` in 1: ALU overflow.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready` at a rising edge.
- `rsp_res` out W: captured result.
- `rsp_car` out 1: captured carry.
- `rsp_of` out 1: captured overflow.
- `rsp_zero` out 1: 1 when the captured result equals 0.
- `acc` out W: accumulator value.
- `ops_done` out CNT_W: completed-operation count.
- `of_count` out CNT_W: count of responses with `of` set.

## Operation
**Op codes**
- 000 add, 001 sub, 010 not A, 011 and, 100 or, 101 xor, 110 signed A<B, 111 A==B.
- The block passes every code through unchanged and never interprets it.

**FSM states**
- IDLE:
  - `cmd_ready`=1.
  - On accept: load `alu_a` (from `acc` if `cmd_use_acc`, else `cmd_a`), `alu_b`=`cmd_b`, `alu_ctrl`=`cmd_op`; go to EXEC.
- EXEC (exactly one cycle):
  - `cmd_ready`=0.
  - At the closing edge: capture `alu_res`, `alu_car`, `alu_of` into the `rsp_*` registers; compute `rsp_zero`.
  - `acc`←`alu_res`.
  - `ops_done`+1; `of_count`+1 if `alu_of`.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; all `rsp_*` fields are held stable.
  - On `rsp_ready`, go to IDLE.
  - `cmd_ready` stays 0 (one command outstanding at most).

**Held values and counters**
- `alu_a`, `alu_b`, `alu_ctrl` hold their values outside the load edge.
- Counters saturate at 2^CNT_W−1 and never wrap.

**Accumulator clear**
- `acc_clr` zeroes `acc` at the next edge in any state.
- If `acc_clr` is asserted on the EXEC capture edge, the clear wins: `acc`=0. `rsp_res` still captures the ALU result.
- If `acc_clr` is asserted on the accept edge with `cmd_use_acc`=1, operand A uses the pre-clear `acc`.

**Reset**
- Asserting `rsp_ready` while `rsp_valid`=0 has no effect.
- Reset in any state sends the FSM to IDLE and drops the pending command and response without emitting them.
- Values while `rst_n`=0: `cmd_ready`=0, `rsp_valid`=0.
- All data outputs, `acc` and both counters are 0 in reset.
- `cmd_ready` rises to 1 on the first edge after reset deasserts.

## Timing
- Accept at edge T0.
- ALU inputs are valid after T0.
- Capture at T1.
- `rsp_valid` is high after T1.
- Command-to-response latency is 2 cycles.
- Minimum issue interval is 3 cycles (accept, EXEC, RESP with `rsp_ready`=1).
- All outputs are registered; there is no combinational path from any input to any output.
- `alu_res`, `alu_car`, `alu_of` are sampled only on the EXEC closing edge.

## Structure
- Shared package `alu_pkg` holds:
  - the 3-bit op-code localparams (ALU_ADD…ALU_EQ);
  - the FSM state enum (S_IDLE, S_EXEC, S_RESP);
  - the default width W=4.
- The ALU is not instantiated inside; the top level connects the two blocks.
- One sub-module is natural: `sat_counter` (parameterised width, increment enable, synchronous saturate), used twice.

## Test plan
- **Add with overflow:** after reset, issue op=000, a=7, b=1, use_acc=0 → after 2 cycles `rsp_res`=4'b1000, car=0, of=1, zero=0; `of_count`=1.
- **Accumulator chain:**
  - First command: use_acc=1, op=000, b=5 → res=5.
  - Second command: use_acc=1, op=000, b=15 → res=4, car=1, `acc`=4.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles with `cmd_valid`=1 → `cmd_ready` stays 0, all `rsp_*` fields stay stable, and the second command is accepted only on the edge after the RESP handshake.
- **Clear collision:** assert `acc_clr` on the EXEC edge of op=011, a=4'hF, b=4'h6 → `rsp_res`=6 and `acc`=0.
- **Reset mid-operation:** drop `rst_n` in EXEC → `rsp_valid`=0 immediately, counters=0, and no response appears after release.
- **Counter saturation:** run 260 ops of op=111, a=b=3 → `ops_done`=255, every `rsp_res`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: op codes, FSM states, default width.
`timescale 1ns/1ps
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_seq_sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
`timescale 1ns/1ps
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Issues one command at a time to an external combinational ALU, captures its
// result after one settle cycle and returns it; keeps an accumulator and stats.
//
// state  | meaning
// S_IDLE | ready for a command; operands loaded on accept
// S_EXEC | ALU settling on registered operands; result captured at closing edge
// S_RESP | response held on rsp_* until rsp_ready
`timescale 1ns/1ps
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_use_acc,
  input  logic             acc_clr,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [W-1:0]     alu_res,
  input  logic             alu_car,
  input  logic             alu_of,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_res,
  output logic             rsp_car,
  output logic             rsp_of,
  output logic             rsp_zero,
  output logic [W-1:0]     acc,
  output logic [CNT_W-1:0] ops_done,
  output logic [CNT_W-1:0] of_count
);

  state_t state, state_nx;
  logic   accept, capture, ready_nx, valid_nx;

  // cmd_ready/rsp_valid are flops so they read 0 in reset and rise one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cmd_ready <= ready_nx;
      rsp_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_EXEC;
      S_EXEC:  state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == S_IDLE) && cmd_valid && cmd_ready;
    capture  = (state == S_EXEC);
    ready_nx = (state_nx == S_IDLE);
    valid_nx = (state_nx == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
      rsp_res  <= '0;
      rsp_car  <= 1'b0;
      rsp_of   <= 1'b0;
      rsp_zero <= 1'b0;
    end else begin
      if (accept) begin
        alu_a    <= cmd_use_acc ? acc : cmd_a;
        alu_b    <= cmd_b;
        alu_ctrl <= cmd_op;
      end
      if (capture) begin
        rsp_res  <= alu_res;
        rsp_car  <= alu_car;
        rsp_of   <= alu_of;
        rsp_zero <= (alu_res == '0);
      end
    end
  end

  // a clear on the capture edge beats the incoming result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (capture) begin
      acc <= alu_res;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_ops_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (capture),
    .count (ops_done)
  );

  sat_counter #(.CNT_W(CNT_W)) u_of_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (capture && alu_of),
    .count (of_count)
  );

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq with a behavioural 4-bit ALU in the loop.
`timescale 1ns/1ps
module tb_alu_issue_seq;

  localparam int W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [W-1:0]     cmd_a = '0;
  logic [W-1:0]     cmd_b = '0;
  logic             cmd_use_acc = 1'b0;
  logic             acc_clr = 1'b0;
  logic [W-1:0]     alu_a, alu_b;
  logic [2:0]       alu_ctrl;
  logic [W-1:0]     alu_res;
  logic             alu_car, alu_of;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [W-1:0]     rsp_res;
  logic             rsp_car, rsp_of, rsp_zero;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] ops_done, of_count;

  typedef struct packed {
    logic [W-1:0] res;
    logic         car;
    logic         of;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_seq #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_car(rsp_car), .rsp_of(rsp_of), .rsp_zero(rsp_zero),
    .acc(acc), .ops_done(ops_done), .of_count(of_count)
  );

  // behavioural ALU downstream of the sequencer
  always_comb begin
    logic [W:0] t;
    t       = '0;
    alu_res = '0;
    alu_car = 1'b0;
    alu_of  = 1'b0;
    case (alu_ctrl)
      3'b000: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res = t[W-1:0];
        alu_car = t[W];
        alu_of  = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
      end
      3'b001: begin
        t = {1'b0, alu_a} - {1'b0, alu_b};
        alu_res = t[W-1:0];
        alu_car = t[W];
        alu_of  = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
      end
      3'b010: alu_res = ~alu_a;
      3'b011: alu_res = alu_a & alu_b;
      3'b100: alu_res = alu_a | alu_b;
      3'b101: alu_res = alu_a ^ alu_b;
      3'b110: alu_res = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_res = {{(W-1){1'b0}}, (alu_a == alu_b)};
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every consumed response must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got res %0h with no expected response at %0t", rsp_res, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_res",  32'(rsp_res),  32'(e.res));
        chk("rsp_car",  32'(rsp_car),  32'(e.car));
        chk("rsp_of",   32'(rsp_of),   32'(e.of));
        chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("rsp_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ua);
    wait_ready();
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ua, input logic [W-1:0] er, input logic ec, input logic eo);
    send(op, a, b, ua);
    sb.push_back('{er, ec, eo, (er == '0)});
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_acc",       32'(acc),       32'd0);
    chk("rst_ops_done",  32'(ops_done),  32'd0);
    chk("rst_alu_a",     32'(alu_a),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // add with overflow and latency
    send(3'b000, 4'd7, 4'd1, 1'b0);
    sb.push_back('{4'b1000, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    chk("exec_alu_a",     32'(alu_a),     32'd7);
    chk("exec_alu_b",     32'(alu_b),     32'd1);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();
    chk("of_count_add", 32'(of_count), 32'd1);
    chk("ops_done_add", 32'(ops_done), 32'd1);
    chk("acc_add",      32'(acc),      32'd8);

    // accumulator chain; cmd_a must be ignored
    @(negedge clk);
    acc_clr = 1'b1;
    @(posedge clk);
    #1 acc_clr = 1'b0;
    @(negedge clk);
    chk("acc_cleared", 32'(acc), 32'd0);
    do_cmd(3'b000, 4'd9, 4'd5,  1'b1, 4'd5, 1'b0, 1'b0);
    do_cmd(3'b000, 4'd9, 4'd15, 1'b1, 4'd4, 1'b1, 1'b0);
    chk("acc_chain", 32'(acc), 32'd4);

    // clear on accept edge: operand uses pre-clear acc
    wait_ready();
    cmd_op = 3'b000; cmd_a = 4'hF; cmd_b = 4'd1; cmd_use_acc = 1'b1;
    acc_clr = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 begin cmd_valid = 1'b0; acc_clr = 1'b0; end
    sb.push_back('{4'd5, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    chk("clr_accept_alu_a", 32'(alu_a), 32'd4);
    drain();
    chk("clr_accept_acc", 32'(acc), 32'd5);

    // backpressure with a second command waiting
    rsp_ready = 1'b0;
    send(3'b100, 4'd3, 4'd4, 1'b0);
    sb.push_back('{4'd7, 1'b0, 1'b0, 1'b0});
    cmd_op = 3'b101; cmd_a = 4'd5; cmd_b = 4'd5; cmd_use_acc = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_res",   32'(rsp_res),   32'd7);
      chk("bp_alu_ctrl",  32'(alu_ctrl),  32'd4);
      @(posedge clk);
      #1;
      if (i < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_after_hs", 32'(cmd_ready), 32'd1);
    chk("bp_not_yet_loaded", 32'(alu_ctrl),  32'd4);
    sb.push_back('{4'd0, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_ctrl", 32'(alu_ctrl), 32'd5);
    chk("bp_second_a",    32'(alu_a),    32'd5);
    drain();

    // clear collides with capture
    send(3'b011, 4'hF, 4'h6, 1'b0);
    acc_clr = 1'b1;
    sb.push_back('{4'd6, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1 acc_clr = 1'b0;
    @(negedge clk);
    chk("collide_acc",     32'(acc),     32'd0);
    chk("collide_rsp_res", 32'(rsp_res), 32'd6);
    drain();

    // reset in EXEC drops the command
    send(3'b000, 4'd1, 4'd1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_ops_done",  32'(ops_done),  32'd0);
    chk("midrst_of_count",  32'(of_count),  32'd0);
    chk("midrst_acc",       32'(acc),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("midrst_ready_up", 32'(cmd_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);

    // counter saturation
    for (int i = 0; i < 260; i++) do_cmd(3'b111, 4'd3, 4'd3, 1'b0, 4'd1, 1'b0, 1'b0);
    chk("sat_ops_done", 32'(ops_done), 32'd255);
    chk("sat_of_count", 32'(of_count), 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
